// File: rtl/registrador_pkg.sv
// registrador_pkg
// Shared definitions for the 16-bit universal shift register (registrador)
// and its command sequencer (registrador_ctrl): command opcodes, register
// mode-line encoding, sequencer FSM states and the default register width.
package registrador_pkg;

  localparam int WIDTH = 16;

  // Command opcodes presented on registrador_ctrl.op
  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SHIFT  = 2'b01,
    OP_ROTATE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  // Register mode lines {ch1, ch0}
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_ROT   = 2'b11
  } mode_e;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/registrador_ctrl_cnt.sv
// registrador_ctrl_cnt
// Loadable down-counter used by registrador_ctrl to time how many clocks a
// register mode stays applied. Decrementing saturates at zero.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val (has priority over dec)
//   load_val in   CNT_W  value to load
//   dec      in   decrement by one when non-zero
//   zero     out  count is 0
//   last     out  count is 1 (the current cycle is the final step)
module registrador_ctrl_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt_r;

  // Step counter: load on accept, count down while the mode is applied
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});
  assign last = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/registrador_ctrl.sv
// registrador_ctrl
// Command sequencer for the universal shift register registrador. Accepts
// one command per start/ready handshake, drives the register's mode lines,
// serial input and parallel-load bus for the required number of clocks, then
// reports the register contents with a one-cycle done pulse.
// Optional build macro: REGISTRADOR_CTRL_CAPTURE_EN
//   defined   -> result is a register loaded in DONE and held until the next DONE
//   undefined -> result follows reg_q combinationally
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   start, op, count  command request, opcode, step count (SHIFT/ROTATE)
//   data_in, fill_bit LOAD value, serial fill bit for SHIFT
//   reg_q             register outputs fed back
//   ready, busy, done handshake / status, one-cycle completion pulse
//   result            register value after the last completed command
//   ch1, ch0, d, bits registered drive to the register
module registrador_ctrl #(
  parameter int WIDTH = registrador_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fill_bit,
  input  logic [WIDTH-1:0] reg_q,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ch1,
  output logic             ch0,
  output logic             d,
  output logic [WIDTH-1:0] bits
);

  import registrador_pkg::*;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e           state_r;
  mode_e            mode_r;
  logic             d_r;
  logic [WIDTH-1:0] bits_r;
  logic             ready_r;
  logic             done_r;

  logic [CNT_W-1:0] steps_s;
  mode_e            mode_s;
  logic [WIDTH-1:0] bits_s;
  logic             d_s;
  logic             accept_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;
  logic             cnt_last_s;

  // Decode the incoming command into step count and the drive it needs
  always_comb begin
    steps_s = {CNT_W{1'b0}};
    mode_s  = MODE_HOLD;
    bits_s  = {WIDTH{1'b0}};
    d_s     = 1'b0;
    case (op_e'(op))
      OP_LOAD: begin
        steps_s = ONE_C;
        mode_s  = MODE_LOAD;
        bits_s  = data_in;
      end
      OP_CLEAR: begin
        steps_s = ONE_C;
        mode_s  = MODE_LOAD;
      end
      OP_SHIFT: begin
        // More than WIDTH shifts is indistinguishable from WIDTH shifts
        steps_s = (count > WIDTH_C) ? WIDTH_C : count;
        mode_s  = MODE_SHIFT;
        d_s     = fill_bit;
      end
      OP_ROTATE: begin
        // A full revolution is a no-op, so only the remainder is executed
        steps_s = count % WIDTH_C;
        mode_s  = MODE_ROT;
      end
      default: begin
        steps_s = {CNT_W{1'b0}};
        mode_s  = MODE_HOLD;
      end
    endcase
  end

  assign accept_s  = (state_r == ST_IDLE) && ready_r && start;
  assign cnt_dec_s = (state_r == ST_RUN);

  registrador_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .load_val (steps_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s),
    .last     (cnt_last_s)
  );

  // Sequencer FSM with registered register-drive and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_HOLD;
      d_r     <= 1'b0;
      bits_r  <= {WIDTH{1'b0}};
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // ready re-asserts only once the done pulse has been seen
          if (done_r) begin
            ready_r <= 1'b1;
          end
          if (accept_s) begin
            ready_r <= 1'b0;
            if (steps_s == {CNT_W{1'b0}}) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_RUN;
              mode_r  <= mode_s;
              d_r     <= d_s;
              bits_r  <= bits_s;
            end
          end
        end
        ST_RUN: begin
          // zero is a safety net; the normal exit is on the last step
          if (cnt_last_s || cnt_zero_s) begin
            state_r <= ST_DONE;
            mode_r  <= MODE_HOLD;
            d_r     <= 1'b0;
            bits_r  <= {WIDTH{1'b0}};
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          mode_r  <= MODE_HOLD;
          d_r     <= 1'b0;
          bits_r  <= {WIDTH{1'b0}};
          ready_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef REGISTRADOR_CTRL_CAPTURE_EN
  logic [WIDTH-1:0] result_r;

  // Capture the settled register contents in the DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_DONE) begin
      result_r <= reg_q;
    end else begin
      result_r <= result_r;
    end
  end

  assign result = result_r;
`else
  // The register holds after DONE, so reg_q already is the post-command value
  assign result = reg_q;
`endif

  assign ready = ready_r;
  assign busy  = ~ready_r;
  assign done  = done_r;
  assign ch1   = mode_r[1];
  assign ch0   = mode_r[0];
  assign d     = d_r;
  assign bits  = bits_r;

endmodule
